// File: rtl/ram_cmd_arbiter.sv
// Two-requester round-robin arbiter that turns one word request into the RAM's two-command sequence.
// Optional read-response watchdog enabled by defining ARB_TIMEOUT_EN.
module ram_cmd_arbiter #(
    parameter int ADDR_SIZE   = 8,
    parameter int DATA_SIZE   = 8,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic                 req0_wr,
    input  logic [ADDR_SIZE-1:0] req0_addr,
    input  logic [DATA_SIZE-1:0] req0_wdata,
    output logic                 req0_done,
    output logic [DATA_SIZE-1:0] req0_rdata,
    output logic                 req0_err,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic                 req1_wr,
    input  logic [ADDR_SIZE-1:0] req1_addr,
    input  logic [DATA_SIZE-1:0] req1_wdata,
    output logic                 req1_done,
    output logic [DATA_SIZE-1:0] req1_rdata,
    output logic                 req1_err,
    output logic [9:0]           ram_din,
    output logic                 ram_rx_valid,
    input  logic [DATA_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid,
    output logic                 busy,
    output logic                 grant_id
);

    localparam logic [1:0] OP_SET_WADDR = 2'b00;
    localparam logic [1:0] OP_WDATA     = 2'b01;
    localparam logic [1:0] OP_SET_RADDR = 2'b10;
    localparam logic [1:0] OP_READ      = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD1,
        S_CMD2,
        S_WAIT_RD,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic                 last_grant_q, grant_n;
    logic                 wr_q, wr_n;
    logic [ADDR_SIZE-1:0] addr_q, addr_n;
    logic [DATA_SIZE-1:0] wdata_q, wdata_n;

    logic                 idle, pick1, accept;
    logic                 timeout_hit;
    logic                 rx_valid_d;
    logic [9:0]           din_d;
    logic                 enter_done, load_rd;
    logic [DATA_SIZE-1:0] rd_n;

    logic                 rx_valid_q;
    logic [9:0]           din_q;
    logic                 done0_q, done1_q;
    logic [DATA_SIZE-1:0] rdata0_q, rdata1_q;

    // With both requesters valid, the one not served last wins.
    assign idle       = (state_q == S_IDLE);
    assign pick1      = req1_valid & (~req0_valid | ~last_grant_q);
    assign req0_ready = idle & req0_valid & ~pick1;
    assign req1_ready = idle & pick1;
    assign accept     = req0_ready | req1_ready;

    always_comb begin
        // NOTE: every combinational output is given a default first so no latch is inferred.
        wr_n    = wr_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        grant_n = last_grant_q;
        if (accept) begin
            grant_n = pick1;
            wr_n    = pick1 ? req1_wr    : req0_wr;
            addr_n  = pick1 ? req1_addr  : req0_addr;
            wdata_n = pick1 ? req1_wdata : req0_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = S_CMD1;
            S_CMD1:    state_d = S_CMD2;
            S_CMD2:    state_d = wr_q ? S_DONE : S_WAIT_RD;
            S_WAIT_RD: if (ram_tx_valid || timeout_hit) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Command outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        rx_valid_d = 1'b0;
        din_d      = '0;
        case (state_d)
            S_CMD1: begin
                rx_valid_d = 1'b1;
                din_d      = {(wr_n ? OP_SET_WADDR : OP_SET_RADDR), 8'(addr_n)};
            end
            S_CMD2: begin
                rx_valid_d = 1'b1;
                din_d      = wr_n ? {OP_WDATA, 8'(wdata_n)} : {OP_READ, 8'h00};
            end
            default: begin
                rx_valid_d = 1'b0;
                din_d      = '0;
            end
        endcase
    end

    assign enter_done = (state_d == S_DONE) && (state_q != S_DONE);
    assign load_rd    = (state_q == S_WAIT_RD) && (state_d == S_DONE);
    assign rd_n       = ram_tx_valid ? ram_dout : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rx_valid_q   <= 1'b0;
            din_q        <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            last_grant_q <= grant_n;
            wr_q         <= wr_n;
            addr_q       <= addr_n;
            wdata_q      <= wdata_n;
            rx_valid_q   <= rx_valid_d;
            din_q        <= din_d;
            done0_q      <= enter_done & ~grant_n;
            done1_q      <= enter_done & grant_n;
            if (load_rd && !grant_n) rdata0_q <= rd_n;
            if (load_rd && grant_n)  rdata1_q <= rd_n;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            err0_q, err1_q;

    assign timeout_hit = (state_q == S_WAIT_RD) && !ram_tx_valid &&
                         (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            if (state_q != S_WAIT_RD) to_cnt_q <= '0;
            else if (!ram_tx_valid)   to_cnt_q <= to_cnt_q + 1'b1;
            err0_q <= load_rd & ~ram_tx_valid & ~grant_n;
            err1_q <= load_rd & ~ram_tx_valid & grant_n;
        end
    end

    assign req0_err = err0_q;
    assign req1_err = err1_q;
`else
    // Keeps the watchdog limit referenced when the watchdog is compiled out.
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign timeout_hit = 1'b0;
    assign req0_err    = 1'b0;
    assign req1_err    = 1'b0;
`endif

    assign ram_din      = din_q;
    assign ram_rx_valid = rx_valid_q;
    assign req0_done    = done0_q;
    assign req1_done    = done1_q;
    assign req0_rdata   = rdata0_q;
    assign req1_rdata   = rdata1_q;
    assign busy         = (state_q != S_IDLE);
    assign grant_id     = last_grant_q;

endmodule

// File: doc/ram_cmd_arbiter.md
Name: ram_cmd_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the 256x8 single-port RAM and its 10-bit command interface.
- Converts one word-level request (write addr/data or read addr) into the RAM's two-command sequence, then returns completion and read data to the granted requester.
- Sits between the SPI-side command decoders and the RAM; the only master of the RAM command port.

Parameters:
- ADDR_SIZE, 8, RAM address width.
- DATA_SIZE, 8, RAM data width.
- TIMEOUT_CYC, 8, read-response watchdog limit in cycles. Used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req0_valid  input  1  requester 0 has a request.
- req0_ready  output  1  request 0 accepted this cycle.
- req0_wr  input  1  1 = write, 0 = read.
- req0_addr  input  ADDR_SIZE  target address.
- req0_wdata  input  DATA_SIZE  write data.
- req0_done  output  1  one-cycle completion pulse.
- req0_rdata  output  DATA_SIZE  read data, valid with req0_done on reads.
- req0_err  output  1  timeout flag, valid with req0_done.
- req1_valid, req1_ready, req1_wr, req1_addr, req1_wdata, req1_done, req1_rdata, req1_err: same as requester 0.
- ram_din  output  10  command word to RAM, {opcode[1:0], payload[7:0]}.
- ram_rx_valid  output  1  command word valid.
- ram_dout  input  DATA_SIZE  RAM read data.
- ram_tx_valid  input  1  RAM read data valid.
- busy  output  1  high whenever state != IDLE.
- grant_id  output  1  requester currently or last served.

Behaviour:
- Opcodes: 00 = set write address, 01 = write data, 10 = set read address, 11 = read.
- States: IDLE, CMD1, CMD2, WAIT_RD, DONE. All state and output registers are updated on the clk rising edge.
- Reset (rst=1 at an edge):
  - state=IDLE, last_grant=1, grant_id=1.
  - ram_din=0, ram_rx_valid=0.
  - All done, err and rdata outputs = 0.
- Reset mid-transaction: the transaction is dropped with no done pulse, and ram_rx_valid is 0 from the next cycle.
- IDLE arbitration (combinational):
  - Only req0_valid high: grant 0. Only req1_valid high: grant 1.
  - Both high: grant = ~last_grant.
  - reqN_ready = (state==IDLE) & granted & reqN_valid. No ready is asserted outside IDLE.
- Handshake (valid & ready at an edge):
  - wr, addr and wdata are captured; last_grant and grant_id are updated; next state is CMD1.
  - Requester fields may change after acceptance.
- CMD1: ram_rx_valid=1; ram_din={00,addr} for a write, {10,addr} for a read. Next state CMD2.
- CMD2: ram_rx_valid=1; ram_din={01,wdata} for a write, {11,8'h00} for a read. Next state is DONE (write) or WAIT_RD (read).
- WAIT_RD:
  - On ram_tx_valid=1: capture ram_dout into rdata, go to DONE.
  - Otherwise stay in WAIT_RD. ram_rx_valid=0 throughout.
- DONE: granted reqN_done=1 for exactly one cycle with rdata/err; next state IDLE. The other requester's done stays 0.
- Outside DONE, reqN_rdata holds its last value.
- ram_tx_valid is ignored outside WAIT_RD.
- ram_rx_valid is 0 in IDLE, WAIT_RD and DONE. Command words are never issued back-to-back across transactions.
- Latency from the accept edge T:
  - Write: done in cycle T+3.
  - Read: done in cycle T+4, given the RAM's 1-cycle tx_valid.
  - Minimum accept-to-accept spacing: write 4 cycles, read 5 cycles.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- Writes with wr=1 never drive opcode 11, so the RAM never raises tx_valid for a write.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_RD and increments each cycle there without ram_tx_valid.
  - Reaching TIMEOUT_CYC moves the block to DONE with err=1 and rdata=0.
  - Counter width is $clog2(TIMEOUT_CYC+1).
- Undefined:
  - No counter is built; WAIT_RD waits indefinitely.
  - reqN_err is tied to 0.

Test Plan:
- Write then read-back: req0 write addr 8'h3C data 8'hA5.
  - ram_din = 10'h03C, then 10'h1A5, in consecutive cycles; req0_done at T+3.
  - Then req0 read 8'h3C: ram_din = 10'h23C, then 10'h300; req0_done at T+4 with rdata=8'hA5, err=0.
- Simultaneous requests: req0 and req1 valid in the same IDLE cycle after reset.
  - req0 is served first, then req1; grant_id goes 0 then 1.
  - With both held valid for 4 transactions, grant order is 0,1,0,1.
- Back-to-back on one requester: req1 writes 8'h01→8'h11 then 8'h02→8'h22 with valid held.
  - Second ready comes 4 cycles after the first.
  - Reads return 8'h11 and 8'h22 on req1 only; req0_done stays 0.
- Reset mid-read: rst=1 during CMD2.
  - Next cycle: ram_rx_valid=0, busy=0, no done pulse.
  - A subsequent req0 request is accepted normally.
- Spurious tx_valid: pulse ram_tx_valid while in IDLE.
  - No state change and no done pulse.
- Timeout (ARB_TIMEOUT_EN defined, TIMEOUT_CYC=8): stub the RAM so ram_tx_valid never rises after a read.
  - req0_done occurs 8 cycles after WAIT_RD entry, with err=1 and rdata=0.
  - Without the macro, busy stays 1 indefinitely.
